// File: rtl/cfg_reg_bank.sv
// Four-register control/status bank behind the AXI4-Lite config slave.
// Optional macro CFG_REGS_COUNT_RDCLR_EN: reading COUNT also clears it.
module cfg_reg_bank #(
    parameter logic [31:0] PARAM_RST = 32'h0000_0000,
    parameter logic [7:0]  MODE_RST  = 8'h00
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_areset,
    input  logic [3:0]  reg_addr,
    input  logic        reg_wr_en,
    input  logic [31:0] reg_wdata,
    input  logic [3:0]  reg_wstrb,
    input  logic        reg_rd_en,
    output logic [31:0] reg_rdata,
    output logic        reg_rvalid,
    input  logic        hw_busy,
    input  logic        hw_done,
    input  logic        hw_err,
    output logic        ctrl_enable,
    output logic [7:0]  ctrl_mode,
    output logic        ctrl_start,
    output logic [31:0] param,
    output logic        irq
);

    logic        irq_en_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] count_q;

    logic        wr_any;
    logic [1:0]  idx;
    logic        ctrl_wr;
    logic        stat_clr_wr;
    logic        cnt_wr;
    logic        start_cmd;
    logic        rd_count_clr;
    logic        done_next;
    logic        err_next;
    logic [31:0] count_next;
    logic [31:0] rd_word;
    logic        unused_addr;

    assign unused_addr = &{1'b0, reg_addr[1:0]};

    always_comb begin
        wr_any      = reg_wr_en && (reg_wstrb != 4'b0000);
        idx         = reg_addr[3:2];
        ctrl_wr     = wr_any && (idx == 2'd0);
        stat_clr_wr = wr_any && (idx == 2'd1) && reg_wstrb[0];
        cnt_wr      = wr_any && (idx == 2'd3);
        // Start requires the post-write enable, which is wdata[0] whenever wstrb[0] is set.
        start_cmd   = ctrl_wr && reg_wstrb[0] && reg_wdata[1] && reg_wdata[0];
`ifdef CFG_REGS_COUNT_RDCLR_EN
        rd_count_clr = reg_rd_en && (idx == 2'd3);
`else
        rd_count_clr = 1'b0;
`endif

        // Hardware set has priority over W1C.
        done_next = hw_done | (done_q & ~(stat_clr_wr & reg_wdata[1]));
        err_next  = hw_err | (start_cmd & hw_busy)
                  | (err_q & ~(stat_clr_wr & reg_wdata[2]));

        count_next = (cnt_wr || rd_count_clr) ? 32'h0 : count_q;
        if (hw_done) begin
            count_next = count_next + 32'h1;
        end

        rd_word = 32'h0;
        case (idx)
            2'd0: rd_word = {16'h0, ctrl_mode, 5'b0, irq_en_q, 1'b0, ctrl_enable};
            2'd1: rd_word = {29'h0, err_q, done_q, hw_busy};
            2'd2: rd_word = param;
            default: rd_word = count_q;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            reg_rdata   <= 32'h0;
            reg_rvalid  <= 1'b0;
            ctrl_start  <= 1'b0;
            irq         <= 1'b0;
            ctrl_enable <= 1'b0;
            irq_en_q    <= 1'b0;
            ctrl_mode   <= MODE_RST;
            param       <= PARAM_RST;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= 32'h0;
        end else begin
            reg_rvalid <= reg_rd_en;
            // Read mux uses current (pre-write) state, so collisions return old data.
            if (reg_rd_en) begin
                reg_rdata <= rd_word;
            end
            ctrl_start <= start_cmd && !hw_busy;
            irq        <= irq_en_q & (done_q | err_q);
            if (ctrl_wr && reg_wstrb[0]) begin
                ctrl_enable <= reg_wdata[0];
                irq_en_q    <= reg_wdata[2];
            end
            if (ctrl_wr && reg_wstrb[1]) begin
                ctrl_mode <= reg_wdata[15:8];
            end
            if (wr_any && (idx == 2'd2)) begin
                for (int b = 0; b < 4; b++) begin
                    if (reg_wstrb[b]) begin
                        param[b*8 +: 8] <= reg_wdata[b*8 +: 8];
                    end
                end
            end
            done_q  <= done_next;
            err_q   <= err_next;
            count_q <= count_next;
        end
    end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Directed bench for cfg_reg_bank: register map, strobes, start pulse, sticky bits, COUNT.
module tb_cfg_reg_bank;

    localparam logic [31:0] PARAM_RST = 32'h0000_0000;
    localparam logic [7:0]  MODE_RST  = 8'h00;

    logic        s_axi_aclk;
    logic        s_axi_areset;
    logic [3:0]  reg_addr;
    logic        reg_wr_en;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_rd_en;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        hw_busy;
    logic        hw_done;
    logic        hw_err;
    logic        ctrl_enable;
    logic [7:0]  ctrl_mode;
    logic        ctrl_start;
    logic [31:0] param;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rd_val;

    cfg_reg_bank #(.PARAM_RST(PARAM_RST), .MODE_RST(MODE_RST)) dut (
        .s_axi_aclk  (s_axi_aclk),
        .s_axi_areset(s_axi_areset),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wdata   (reg_wdata),
        .reg_wstrb   (reg_wstrb),
        .reg_rd_en   (reg_rd_en),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .hw_busy     (hw_busy),
        .hw_done     (hw_done),
        .hw_err      (hw_err),
        .ctrl_enable (ctrl_enable),
        .ctrl_mode   (ctrl_mode),
        .ctrl_start  (ctrl_start),
        .param       (param),
        .irq         (irq)
    );

    initial s_axi_aclk = 1'b0;
    always #5 s_axi_aclk = ~s_axi_aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge s_axi_aclk);
        reg_addr = a; reg_wdata = d; reg_wstrb = s; reg_wr_en = 1'b1;
        @(negedge s_axi_aclk);
        reg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge s_axi_aclk);
        reg_addr = a; reg_rd_en = 1'b1;
        @(negedge s_axi_aclk);
        reg_rd_en = 1'b0;
        chk("rvalid_hi", {31'h0, reg_rvalid}, 32'h1);
        d = reg_rdata;
        @(negedge s_axi_aclk);
        chk("rvalid_lo", {31'h0, reg_rvalid}, 32'h0);
    endtask

    task automatic pulse_done();
        @(negedge s_axi_aclk);
        hw_done = 1'b1;
        @(negedge s_axi_aclk);
        hw_done = 1'b0;
    endtask

    initial begin
        s_axi_areset = 1'b1;
        reg_addr = 4'h0; reg_wr_en = 1'b0; reg_wdata = 32'h0; reg_wstrb = 4'h0;
        reg_rd_en = 1'b0; hw_busy = 1'b0; hw_done = 1'b0; hw_err = 1'b0;
        repeat (3) @(negedge s_axi_aclk);
        chk("rst_rdata", reg_rdata, 32'h0);
        chk("rst_rvalid", {31'h0, reg_rvalid}, 32'h0);
        chk("rst_start", {31'h0, ctrl_start}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_mode", {24'h0, ctrl_mode}, {24'h0, MODE_RST});
        chk("rst_param", param, PARAM_RST);
        s_axi_areset = 1'b0;

        rd(4'h0, rd_val); chk("rd_ctrl_rst", rd_val, 32'h0);
        hw_busy = 1'b1;
        rd(4'h4, rd_val); chk("rd_status_busy", rd_val, 32'h1);
        hw_busy = 1'b0;
        rd(4'h8, rd_val); chk("rd_param_rst", rd_val, PARAM_RST);
        rd(4'hC, rd_val); chk("rd_count_rst", rd_val, 32'h0);

        // PARAM byte strobes
        wr(4'h8, 32'hAABB_CCDD, 4'b0101);
        rd(4'h8, rd_val); chk("param_strb", rd_val, 32'h00BB_00DD);
        wr(4'h8, 32'hFFFF_FFFF, 4'b0000);
        rd(4'h8, rd_val); chk("param_strb0", rd_val, 32'h00BB_00DD);

        // read/write collision returns pre-write data
        @(negedge s_axi_aclk);
        reg_addr = 4'h8; reg_wdata = 32'h1122_3344; reg_wstrb = 4'hF;
        reg_wr_en = 1'b1; reg_rd_en = 1'b1;
        @(negedge s_axi_aclk);
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        chk("coll_rdata", reg_rdata, 32'h00BB_00DD);
        rd(4'h8, rd_val); chk("coll_after", rd_val, 32'h1122_3344);

        // start pulse
        wr(4'h0, 32'h0000_0005, 4'b0001);
        chk("enable", {31'h0, ctrl_enable}, 32'h1);
        chk("start_none", {31'h0, ctrl_start}, 32'h0);
        wr(4'h0, 32'h0000_0007, 4'b0001);
        chk("start_hi", {31'h0, ctrl_start}, 32'h1);
        @(negedge s_axi_aclk);
        chk("start_lo", {31'h0, ctrl_start}, 32'h0);
        rd(4'h0, rd_val); chk("ctrl_rb", rd_val, 32'h0000_0005);
        wr(4'h0, 32'h0000_AB00, 4'b0010);
        chk("mode", {24'h0, ctrl_mode}, 32'h0000_00AB);
        rd(4'h0, rd_val); chk("ctrl_mode_rb", rd_val, 32'h0000_AB05);
        wr(4'h0, 32'h0000_0007, 4'b0000);
        chk("start_strb0", {31'h0, ctrl_start}, 32'h0);

        // start while busy -> err, irq one cycle later
        hw_busy = 1'b1;
        wr(4'h0, 32'h0000_AB07, 4'b0001);
        chk("start_busy", {31'h0, ctrl_start}, 32'h0);
        chk("irq_not_yet", {31'h0, irq}, 32'h0);
        @(negedge s_axi_aclk);
        chk("irq_err", {31'h0, irq}, 32'h1);
        hw_busy = 1'b0;
        rd(4'h4, rd_val); chk("status_err", rd_val, 32'h4);
        wr(4'h4, 32'h0000_0004, 4'b0001);
        rd(4'h4, rd_val); chk("status_err_clr", rd_val, 32'h0);
        chk("irq_err_fall", {31'h0, irq}, 32'h0);

        // hw_done with coincident W1C: set wins
        @(negedge s_axi_aclk);
        reg_addr = 4'h4; reg_wdata = 32'h2; reg_wstrb = 4'b0001; reg_wr_en = 1'b1; hw_done = 1'b1;
        @(negedge s_axi_aclk);
        reg_wr_en = 1'b0; hw_done = 1'b0;
        rd(4'h4, rd_val); chk("done_setwins", rd_val, 32'h2);
        chk("irq_done", {31'h0, irq}, 32'h1);
        rd(4'hC, rd_val); chk("count_1", rd_val, 32'h1);
        wr(4'h4, 32'h0000_0002, 4'b0001);
        rd(4'h4, rd_val); chk("done_clr", rd_val, 32'h0);
        chk("irq_done_fall", {31'h0, irq}, 32'h0);

        // hw_err sets err
        @(negedge s_axi_aclk); hw_err = 1'b1;
        @(negedge s_axi_aclk); hw_err = 1'b0;
        rd(4'h4, rd_val); chk("hw_err", rd_val, 32'h4);

        // COUNT
        wr(4'hC, 32'h0, 4'b0001);
        rd(4'hC, rd_val); chk("count_wclr", rd_val, 32'h0);
        pulse_done(); pulse_done(); pulse_done();
        rd(4'hC, rd_val); chk("count_3", rd_val, 32'h3);
        @(negedge s_axi_aclk);
        reg_addr = 4'hC; reg_wdata = 32'hDEAD_BEEF; reg_wstrb = 4'b1000; reg_wr_en = 1'b1; hw_done = 1'b1;
        @(negedge s_axi_aclk);
        reg_wr_en = 1'b0; hw_done = 1'b0;
        rd(4'hC, rd_val); chk("count_wr_done", rd_val, 32'h1);
        wr(4'hC, 32'h0, 4'b0000);
        rd(4'hC, rd_val); chk("count_strb0", rd_val, 32'h1);

        @(negedge s_axi_aclk);
        force dut.count_q = 32'hFFFF_FFFF;
        hw_done = 1'b1;
        #1 release dut.count_q;
        @(negedge s_axi_aclk);
        hw_done = 1'b0;
        rd(4'hC, rd_val); chk("count_wrap", rd_val, 32'h0);

        wr(4'hC, 32'h0, 4'b1111);
        pulse_done(); pulse_done();
        rd(4'hC, rd_val); chk("count_rd1", rd_val, 32'h2);
        rd(4'hC, rd_val);
`ifdef CFG_REGS_COUNT_RDCLR_EN
        chk("count_rd2", rd_val, 32'h0);
`else
        chk("count_rd2", rd_val, 32'h2);
`endif

        // reset drops a pending start pulse
        wr(4'h0, 32'h0000_0005, 4'b0001);
        @(negedge s_axi_aclk);
        reg_addr = 4'h0; reg_wdata = 32'h7; reg_wstrb = 4'b0001; reg_wr_en = 1'b1; s_axi_areset = 1'b1;
        @(negedge s_axi_aclk);
        reg_wr_en = 1'b0; s_axi_areset = 1'b0;
        chk("rst_drop_start", {31'h0, ctrl_start}, 32'h0);
        chk("rst_drop_enable", {31'h0, ctrl_enable}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cfg_reg_bank.md
Name: cfg_reg_bank

Overview:
- Register bank directly downstream of the AXI4-Lite config slave.
- Consumes single-cycle write and read strobes with a 4-bit byte address.
- Holds four 32-bit control and status registers and returns registered read data.
- Drives start and interrupt signals to the datapath and collects done and error events from it.

Parameters:
PARAM_RST, 32'h0000_0000, reset value of the PARAM register
MODE_RST, 8'h00, reset value of CTRL.mode[15:8]

Ports:
s_axi_aclk  in  1  clock
s_axi_areset  in  1  synchronous reset, active-high
reg_addr  in  4  byte address; bits [1:0] ignored
reg_wr_en  in  1  one-cycle write strobe
reg_wdata  in  32  write data
reg_wstrb  in  4  byte enables for the write
reg_rd_en  in  1  one-cycle read strobe
reg_rdata  out  32  read data, registered
reg_rvalid  out  1  read data valid pulse
hw_busy  in  1  datapath busy level
hw_done  in  1  datapath done pulse
hw_err  in  1  datapath error pulse
ctrl_enable  out  1  CTRL.enable
ctrl_mode  out  8  CTRL.mode
ctrl_start  out  1  one-cycle start pulse
param  out  32  PARAM register
irq  out  1  interrupt level, registered

Behaviour:
- Single clock domain. Every flop resets synchronously when s_axi_areset=1.
- Reset values: reg_rdata=0, reg_rvalid=0, ctrl_start=0, irq=0, enable=0, irq_en=0, mode=MODE_RST, param=PARAM_RST, done=0, err=0, count=0.
- Register map (word index = reg_addr[3:2]):
  - 0x0 CTRL:
    - bit0 enable, RW.
    - bit1 start, write-1 pulse; reads back 0.
    - bit2 irq_en, RW.
    - [15:8] mode, RW.
    - other bits read 0.
  - 0x4 STATUS:
    - bit0 busy, RO, reflects hw_busy sampled the same cycle.
    - bit1 done, sticky, W1C.
    - bit2 err, sticky, W1C.
    - other bits read 0.
  - 0x8 PARAM: 32-bit RW, byte-enabled by reg_wstrb.
  - 0xC COUNT: RO count of hw_done pulses, 32-bit, wraps 0xFFFF_FFFF→0. Any write with at least one strobe set clears it.
- Byte strobes:
  - CTRL: wstrb[0] gates bits[7:0]; wstrb[1] gates bits[15:8].
  - STATUS W1C: gated by wstrb[0].
  - Write with wstrb=0: no effect anywhere, including no start pulse.
- Start pulse:
  - CTRL write with wstrb[0]=1 and wdata[1]=1, while enable (post-write value) is 1 and hw_busy is 0 → ctrl_start=1 on the next cycle, exactly one cycle.
  - Same write while hw_busy=1 → no pulse; err set.
  - Same write while enable is 0 → ignored silently.
- Sticky bits:
  - hw_done sets done; hw_err sets err.
  - Hardware set and W1C in the same cycle → set wins (bit stays 1).
- COUNT: hw_done and a COUNT write in the same cycle → COUNT=1.
- Read timing:
  - reg_rd_en in cycle N → reg_rdata valid and reg_rvalid=1 in cycle N+1.
  - reg_rdata holds its value until the next read.
- Read/write collision: reg_rd_en and reg_wr_en in the same cycle → read returns the pre-write value.
- Reads never alter state (see optional feature for the only exception).
- irq = irq_en & (done | err), registered; rises one cycle after the sticky bit sets.
- Reset mid-operation: a pending ctrl_start, reg_rvalid or irq is dropped in the reset cycle.

Optional Feature:
- Macro: CFG_REGS_COUNT_RDCLR_EN.
- Defined:
  - A read of COUNT returns the current value and clears COUNT in the same edge.
  - hw_done coincident with that read → COUNT=1 afterwards; the returned value excludes that event.
  - A simultaneous write-clear and read behave as read-clear.
- Undefined: COUNT reads have no side effect; clearing is by write only.

Test Plan:
- Reset then read 0x0, 0x4, 0x8, 0xC → 0x0000_0000, {29'b0,0,0,hw_busy}, PARAM_RST, 0; reg_rvalid high exactly one cycle after each reg_rd_en.
- Write 0x8 = 0xAABB_CCDD with wstrb=4'b0101 over PARAM=0 → PARAM reads 0x00BB_00DD; a write with wstrb=0 leaves it unchanged.
- Write CTRL=0x0000_0005, then CTRL=0x0000_0007 with hw_busy=0 → ctrl_start high exactly one cycle, CTRL reads 0x0000_0005. Repeat with hw_busy=1 → no pulse, STATUS.err=1, irq=1 one cycle later.
- Pulse hw_done and write STATUS=0x2 in the same cycle → done stays 1, COUNT=1. Next W1C with no hw_done → done=0, irq falls.
- Three hw_done pulses, then read COUNT → 3. Write COUNT=any with hw_done in the same cycle → COUNT reads 1. Preload 0xFFFF_FFFF via bench force then one hw_done → 0.
- With CFG_REGS_COUNT_RDCLR_EN defined: two hw_done pulses, then read COUNT → returns 2; a second read → 0. Without the macro the second read also returns 2.
